// File: rtl/bram_master.sv
// bram_master: burst command front end for one port of a dual-port BRAM.
// Writes stream straight to memory; reads go through a 4-entry credit-controlled buffer.
module bram_master #(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 8
) (
    input  logic              sys_clock,
    input  logic              sys_rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [AWIDTH-1:0] cmd_addr,
    input  logic [AWIDTH-1:0] cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DWIDTH-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DWIDTH-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic              mem_we,
    output logic              mem_oe,
    output logic [AWIDTH-1:0] mem_addr,
    inout  wire  [DWIDTH-1:0] mem_data
);
    typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

    state_t            state_q, state_d;
    logic [AWIDTH-1:0] addr_q, addr_d, rem_q, rem_d, pops_q, pops_d, waddr_q;
    logic [DWIDTH-1:0] wdata_q;
    logic [DWIDTH-1:0] buf_q [4];
    logic [1:0]        wp_q, rp_q;
    logic [2:0]        cnt_q;
    logic              we_q, tag_q, done_q, done_d;
    logic              wr_hs, issue, pop;

    assign cmd_ready = state_q == IDLE;
    assign busy      = state_q != IDLE;
    assign wr_ready  = state_q == WRITE;
    assign mem_oe    = state_q == READ || state_q == DRAIN;
    assign mem_we    = we_q;
    assign mem_addr  = we_q ? waddr_q : addr_q;
    assign mem_data  = we_q ? wdata_q : 'z;
    assign rd_valid  = cnt_q != 3'd0;
    assign rd_data   = buf_q[rp_q];
    assign done      = done_q;
    assign wr_hs     = wr_valid && wr_ready;
    assign pop       = rd_valid && rd_ready;
    // Credit: buffered beats plus the one read returning this cycle must leave room.
    assign issue     = state_q == READ && (cnt_q + 3'(tag_q)) < 3'd4;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        pops_d  = pops_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (cmd_valid) begin
                state_d = cmd_write ? WRITE : READ;
                addr_d  = cmd_addr;
                rem_d   = cmd_len;
                pops_d  = cmd_len;
            end
            WRITE: if (wr_hs) begin
                addr_d  = addr_q + 1'b1;
                rem_d   = rem_q - 1'b1;
                state_d = rem_q == '0 ? IDLE : WRITE;
                done_d  = rem_q == '0;
            end
            READ: if (issue) begin
                addr_d  = addr_q + 1'b1;
                rem_d   = rem_q - 1'b1;
                state_d = rem_q == '0 ? DRAIN : READ;
            end
            default: ;
        endcase
        if (pop) begin
            pops_d = pops_q - 1'b1;
            if (state_q == DRAIN && pops_q == '0) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clock or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            pops_q  <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            tag_q   <= 1'b0;
            done_q  <= 1'b0;
            wp_q    <= '0;
            rp_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            pops_q  <= pops_d;
            we_q    <= wr_hs;
            waddr_q <= wr_hs ? addr_q : waddr_q;
            wdata_q <= wr_hs ? wr_data : wdata_q;
            tag_q   <= issue;
            done_q  <= done_d;
            wp_q    <= wp_q + 2'(tag_q);
            rp_q    <= rp_q + 2'(pop);
            cnt_q   <= cnt_q + 3'(tag_q) - 3'(pop);
        end
    end

    always_ff @(posedge sys_clock) begin
        if (tag_q) buf_q[wp_q] <= mem_data;
    end
endmodule

// File: tb/tb_bram_master.sv
// tb_bram_master: directed burst tests of bram_master against a registered-read BRAM model.
module tb_bram_master;
    logic       sys_clock = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       cmd_valid = 1'b0, cmd_write = 1'b0, wr_valid = 1'b0, rd_ready = 1'b0;
    logic [7:0] cmd_addr = '0, cmd_len = '0, wr_data = '0;
    logic       cmd_ready, wr_ready, rd_valid, busy, done, mem_we, mem_oe;
    logic [7:0] rd_data, mem_addr, rdreg;
    wire  [7:0] mem_data;
    logic [7:0] mem [256];
    logic [7:0] vec [8];
    int         n_chk = 0, n_pass = 0, contention = 0;

    bram_master #(.DWIDTH(8), .AWIDTH(8)) dut (
        .sys_clock(sys_clock), .sys_rst_n(sys_rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .busy(busy), .done(done),
        .mem_we(mem_we), .mem_oe(mem_oe), .mem_addr(mem_addr), .mem_data(mem_data)
    );

    always #5 sys_clock = ~sys_clock;

    // Memory drives read data while enabled, otherwise a fixed idle pattern so a stray master drive shows up.
    assign mem_data = mem_we ? 'z : (mem_oe ? rdreg : 8'hC3);

    always @(posedge sys_clock) begin
        if (mem_we) mem[mem_addr] <= mem_data;
        rdreg <= mem[mem_addr];
    end

    always @(negedge sys_clock) if (mem_we && mem_oe) contention++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic write_burst(input logic [7:0] a, input logic [7:0] len, input logic [7:0] gaps);
        int i = 0;
        int cyc = 0;
        logic prev = 1'b0;
        logic [7:0] pa = '0;
        @(negedge sys_clock);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = a; cmd_len = len;
        @(negedge sys_clock);
        cmd_valid = 1'b0;
        forever begin
            if (prev) begin
                check("wr_we", mem_we, 1);
                check("wr_oe", mem_oe, 0);
                check("wr_addr", mem_addr, pa);
                check("wr_data", mem_data, vec[i-1]);
            end else begin
                check("gap_we", mem_we, 0);
                check("gap_bus", mem_data, 8'hC3);
            end
            if (i > int'(len)) break;
            if (cyc > 40) begin
                check("wr_timeout", 0, 1);
                break;
            end
            wr_valid = !gaps[cyc%8];
            wr_data  = vec[i];
            prev = wr_valid && wr_ready;
            if (prev) begin
                pa = a + 8'(i);
                i++;
            end
            cyc++;
            @(negedge sys_clock);
        end
        wr_valid = 1'b0;
        check("wr_done", done, 1);
        check("wr_idle", {busy, cmd_ready, wr_ready}, 3'b010);
        @(negedge sys_clock);
        check("wr_done_pulse", done, 0);
    endtask

    task automatic read_burst(input logic [7:0] a, input logic [7:0] len, input logic toggle);
        int k = 1;
        int j = 0;
        int first = 0;
        int last = 0;
        @(negedge sys_clock);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = a; cmd_len = len;
        @(negedge sys_clock);
        cmd_valid = 1'b0;
        check("rd_oe", mem_oe, 1);
        while (j <= int'(len) && k < 60) begin
            rd_ready = toggle ? k[0] : 1'b1;
            if (rd_valid && first == 0) first = k;
            if (rd_valid && rd_ready) begin
                check("rd_data", rd_data, vec[j]);
                j++;
                last = k;
            end
            k++;
            @(negedge sys_clock);
        end
        rd_ready = 1'b0;
        check("rd_first", first, 3);
        check("rd_count", j, int'(len) + 1);
        if (!toggle) check("rd_last", last, 3 + int'(len));
        check("rd_done", done, 1);
        check("rd_idle", {busy, mem_oe, rd_valid}, 3'b000);
        @(negedge sys_clock);
        check("rd_done_pulse", done, 0);
    endtask

    initial begin
        int seen;
        int j;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        repeat (2) @(negedge sys_clock);
        check("rst_out", {busy, done, mem_we, mem_oe, rd_valid, wr_ready, cmd_ready}, 7'b0000001);
        check("rst_addr", mem_addr, 0);
        sys_rst_n = 1'b1;

        for (int i = 0; i < 4; i++) vec[i] = 8'hA1 + 8'(i);
        write_burst(8'h10, 8'd3, 8'h00);
        read_burst(8'h10, 8'd3, 1'b0);

        for (int i = 0; i < 3; i++) vec[i] = 8'h01 + 8'(i);
        write_burst(8'hFE, 8'd2, 8'h00);
        read_burst(8'hFE, 8'd2, 1'b0);

        for (int i = 0; i < 8; i++) vec[i] = 8'h31 + 8'(i);
        write_burst(8'h20, 8'd7, 8'b0010_0110);
        read_burst(8'h20, 8'd7, 1'b1);

        @(negedge sys_clock);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h20; cmd_len = 8'd7;
        @(negedge sys_clock);
        cmd_valid = 1'b0;
        rd_ready = 1'b1;
        j = 0;
        for (int k = 0; k < 20 && j < 2; k++) begin
            if (rd_valid) begin
                check("pre_rst_data", rd_data, vec[j]);
                j++;
            end
            @(negedge sys_clock);
        end
        sys_rst_n = 1'b0;
        #1;
        check("mid_rst_out", {busy, done, mem_we, mem_oe, rd_valid, wr_ready}, 6'b000000);
        check("mid_rst_addr", mem_addr, 0);
        check("mid_rst_bus", mem_data, 8'hC3);
        @(negedge sys_clock);
        sys_rst_n = 1'b1;
        rd_ready = 1'b0;
        seen = 0;
        repeat (10) begin
            @(negedge sys_clock);
            if (done || rd_valid) seen++;
        end
        check("rst_no_done", seen, 0);
        check("rst_cmd_ready", cmd_ready, 1);

        for (int i = 0; i < 4; i++) vec[i] = 8'hA1 + 8'(i);
        read_burst(8'h10, 8'd3, 1'b0);

        check("contention", contention, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
